pov_panel_driver: RTL

Sequencer and HUB75 driver that consumes column data from the sphere frame generators. For each frame it latches `dtheta` and walks the 32 scan lines. On each line it presents a column-index pair to the generator and captures the returned 2×64 pixels. It then shifts those pixels into the LED panel as 3-bit-per-channel binary-coded-modulation bit planes. It sits between the rotation/angle tracker and the panel connector pins.

---
 rtl/pov_pkg.sv | 24 ++
 rtl/hub75_pixel_shifter.sv | 72 +++++++
 rtl/pov_panel_driver.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pov_pkg.sv
// Shared types and constants for the POV panel driver: FSM states,
// pixel layout and bit-plane count.
package pov_pkg;

  localparam int RGB_RES = 9;
  localparam int PLANES  = RGB_RES / 3;
  localparam int PLANE_W = $clog2(PLANES);
  localparam int IDX_W   = $clog2(RGB_RES);

  localparam int R_OFS = 6;
  localparam int G_OFS = 3;
  localparam int B_OFS = 0;

  typedef logic [RGB_RES-1:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } state_t;

endpackage

// File: rtl/hub75_pixel_shifter.sv
// Serialises one bit plane of a captured scan line onto the HUB75 data pins,
// generating the panel shift clock with a CLK_DIV-cycle half period.
module hub75_pixel_shifter
  import pov_pkg::*;
#(
  parameter int NUM_ROWS = 64,
  parameter int CLK_DIV  = 2
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_start,
  input  logic [PLANE_W-1:0]                     i_plane,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  i_line,
  output logic                                   o_clk,
  output logic                                   o_done,
  output logic [2:0]                             o_rgb0,
  output logic [2:0]                             o_rgb1
);

  localparam int PH_W = $clog2(2 * CLK_DIV);
  localparam int PX_W = $clog2(NUM_ROWS);
  localparam logic [PH_W-1:0] PH_HIGH  = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PX_W-1:0] PX_FIRST = PX_W'(NUM_ROWS - 1);

  logic            r_active;
  logic [PH_W-1:0] r_phase;
  logic [PX_W-1:0] r_pix;

  pixel_t          w_pix0;
  pixel_t          w_pix1;
  logic [IDX_W-1:0] w_rIdx;
  logic [IDX_W-1:0] w_gIdx;
  logic [IDX_W-1:0] w_bIdx;

  // Pixels leave highest row first; each pixel gets a low then a high half period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_phase  <= '0;
      r_pix    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_phase  <= '0;
      r_pix    <= PX_FIRST;
    end else if (r_active) begin
      if (r_phase == PH_LAST) begin
        r_phase <= '0;
        if (r_pix == '0) begin
          r_active <= 1'b0;
        end else begin
          r_pix <= r_pix - 1'b1;
        end
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  assign o_done = r_active && (r_phase == PH_LAST) && (r_pix == '0);
  assign o_clk  = r_active && (r_phase >= PH_HIGH);

  assign w_pix0 = i_line[0][r_pix];
  assign w_pix1 = i_line[1][r_pix];
  assign w_rIdx = IDX_W'(R_OFS) + IDX_W'(i_plane);
  assign w_gIdx = IDX_W'(G_OFS) + IDX_W'(i_plane);
  assign w_bIdx = IDX_W'(B_OFS) + IDX_W'(i_plane);

  assign o_rgb0 = r_active ? {w_pix0[w_rIdx], w_pix0[w_gIdx], w_pix0[w_bIdx]} : 3'b000;
  assign o_rgb1 = r_active ? {w_pix1[w_rIdx], w_pix1[w_gIdx], w_pix1[w_bIdx]} : 3'b000;

endmodule

// File: rtl/pov_panel_driver.sv
// Frame sequencer and HUB75 driver: fetches each scan line from the sphere
// generator and shows it as BCM bit planes. Optional: POV_DRIVER_OVERRUN_EN.
module pov_panel_driver
  import pov_pkg::*;
#(
  parameter int ROTATIONAL_RES = 256,
  parameter int SCAN_RATE      = 32,
  parameter int NUM_ROWS       = 64,
  parameter int CLK_DIV        = 2,
  parameter int BASE_ON        = 4
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic [$clog2(ROTATIONAL_RES)-1:0]      dtheta_in,
  input  logic                                   frame_start_in,
  output logic [$clog2(ROTATIONAL_RES)-1:0]      dtheta_out,
  output logic [$clog2(SCAN_RATE)-1:0]           column_index1_out,
  output logic [$clog2(SCAN_RATE):0]             column_index2_out,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  columns_in,
  output logic [2:0]                             rgb0_out,
  output logic [2:0]                             rgb1_out,
  output logic [$clog2(SCAN_RATE)-1:0]           addr_out,
  output logic                                   clk_out,
  output logic                                   latch_out,
  output logic                                   oe_n_out,
  output logic                                   busy_out,
  output logic                                   done_out,
  output logic                                   overrun_out
);

  localparam int AW = $clog2(ROTATIONAL_RES);
  localparam int LW = $clog2(SCAN_RATE);
  localparam int CW = LW + 1;
  localparam int DW = $clog2((BASE_ON << (PLANES - 1)) + 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(PLANES - 1);
  localparam logic [LW-1:0]      LAST_LINE  = LW'(SCAN_RATE - 1);

  state_t r_state;
  state_t w_next;

  logic [AW-1:0]      r_dtheta;
  logic [LW-1:0]      r_line;
  logic [CW-1:0]      r_col2;
  logic [PLANE_W-1:0] r_plane;
  logic [DW-1:0]      r_disp;
  logic [LW-1:0]      r_addr;
  logic               r_done;
  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] r_lineBuf;

  logic          w_accept;
  logic          w_shiftStart;
  logic          w_shiftDone;
  logic          w_dispLast;
  logic [DW-1:0] w_dispEnd;

  // A start landing on the done cycle is dropped so frames never overlap.
  assign w_accept   = (r_state == ST_IDLE) && frame_start_in && !r_done;
  assign w_dispEnd  = (DW'(BASE_ON) << r_plane) - DW'(1);
  assign w_dispLast = (r_disp == w_dispEnd);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_shiftStart = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_next       = ST_SHIFT;
        w_shiftStart = 1'b1;
      end
      ST_SHIFT: begin
        if (w_shiftDone) w_next = ST_LATCH;
      end
      ST_LATCH: begin
        w_next = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        if (w_dispLast) begin
          if (r_plane != LAST_PLANE) begin
            w_next       = ST_SHIFT;
            w_shiftStart = 1'b1;
          end else if (r_line != LAST_LINE) begin
            w_next = ST_FETCH;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_dtheta <= '0;
      r_line   <= '0;
      r_col2   <= '0;
      r_plane  <= '0;
      r_disp   <= '0;
      r_addr   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_dtheta <= dtheta_in;
            r_line   <= '0;
            r_col2   <= CW'(SCAN_RATE);
          end
        end
        ST_FETCH: begin
          r_plane <= '0;
        end
        ST_SHIFT: begin
          if (w_shiftDone) r_addr <= r_line;
        end
        ST_LATCH: begin
          r_disp <= '0;
        end
        ST_DISPLAY: begin
          r_disp <= r_disp + 1'b1;
          if (w_dispLast) begin
            if (r_plane != LAST_PLANE) begin
              r_plane <= r_plane + 1'b1;
            end else if (r_line != LAST_LINE) begin
              r_line <= r_line + 1'b1;
              r_col2 <= r_col2 + 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line buffer needs no reset; it is always refilled before it is shifted.
  always_ff @(posedge clk_in) begin
    if (r_state == ST_FETCH) r_lineBuf <= columns_in;
  end

  hub75_pixel_shifter #(
    .NUM_ROWS (NUM_ROWS),
    .CLK_DIV  (CLK_DIV)
  ) u_shifter (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_start (w_shiftStart),
    .i_plane (r_plane),
    .i_line  (r_lineBuf),
    .o_clk   (clk_out),
    .o_done  (w_shiftDone),
    .o_rgb0  (rgb0_out),
    .o_rgb1  (rgb1_out)
  );

  assign dtheta_out        = r_dtheta;
  assign column_index1_out = r_line;
  assign column_index2_out = r_col2;
  assign addr_out          = r_addr;
  assign latch_out         = (r_state == ST_LATCH);
  assign oe_n_out          = (r_state != ST_DISPLAY);
  assign busy_out          = (r_state != ST_IDLE);
  assign done_out          = r_done;

`ifdef POV_DRIVER_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_overrun <= 1'b0;
    end else if (frame_start_in && busy_out) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun_out = r_overrun;
`else
  assign overrun_out = 1'b0;
`endif

endmodule
